// File: rtl/vmem_fill_arbiter.sv
// Video-memory write arbiter: merges CPU byte writes with a rectangular-free
// linear fill engine. CPU writes always win; the fill advances only on idle
// cycles and is clipped at the end of the framebuffer.
module vmem_fill_arbiter #(
    parameter int unsigned PIXEL_COUNT = 256000
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        fill_start,
    input  logic        fill_abort,
    input  logic [31:0] fill_base,
    input  logic [17:0] fill_len,
    input  logic [7:0]  fill_color,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        vm_wr,
    output logic [31:0] vm_addr,
    output logic [7:0]  vm_data
);

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 18;
    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] PIX_LIMIT = AW'(PIXEL_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [LW-1:0]   remaining_q, remaining_d;
    logic [DW-1:0]   color_q, color_d;
    logic            vm_wr_q, vm_wr_d;
    logic [AW-1:0]   vm_addr_q, vm_addr_d;
    logic [DW-1:0]   vm_data_q, vm_data_d;
    logic            busy_q, done_q;

    // State register and registered write port.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            color_q     <= '0;
            vm_wr_q     <= 1'b0;
            vm_addr_q   <= '0;
            vm_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            color_q     <= color_d;
            vm_wr_q     <= vm_wr_d;
            vm_addr_q   <= vm_addr_d;
            vm_data_q   <= vm_data_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    // Arbitration and fill sequencing; CPU path first, fill only when CPU is quiet.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        color_d     = color_q;
        vm_wr_d     = 1'b0;
        vm_addr_d   = vm_addr_q;
        vm_data_d   = vm_data_q;

        // Out-of-range CPU writes are dropped but still block the fill.
        if (cpu_wr && (cpu_addr < PIX_LIMIT)) begin
            vm_wr_d   = 1'b1;
            vm_addr_d = cpu_addr;
            vm_data_d = cpu_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    cur_addr_d  = fill_base;
                    remaining_d = fill_len;
                    color_d     = fill_color;
                    state_d     = (fill_len == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_abort) begin
                    state_d = ST_IDLE;
                end else if (cur_addr_q >= PIX_LIMIT) begin
                    state_d = ST_DONE;
                end else if (!cpu_wr) begin
                    vm_wr_d     = 1'b1;
                    vm_addr_d   = cur_addr_q;
                    vm_data_d   = color_q;
                    cur_addr_d  = cur_addr_q + AW'(1);
                    remaining_d = remaining_q - LW'(1);
                    if (remaining_q == LW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fill_busy = busy_q;
    assign fill_done = done_q;
    assign vm_wr     = vm_wr_q;
    assign vm_addr   = vm_addr_q;
    assign vm_data   = vm_data_q;

endmodule

// File: tb/tb_vmem_fill_arbiter.sv
// Bench for vmem_fill_arbiter: directed scenarios plus a randomized run,
// every cycle checked against a transaction-level reference model.
module tb_vmem_fill_arbiter;

    localparam int unsigned PC = 256000;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        fill_start;
    logic        fill_abort;
    logic [31:0] fill_base;
    logic [17:0] fill_len;
    logic [7:0]  fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        vm_wr;
    logic [31:0] vm_addr;
    logic [7:0]  vm_data;

    vmem_fill_arbiter #(.PIXEL_COUNT(PC)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .fill_start(fill_start),
        .fill_abort(fill_abort),
        .fill_base (fill_base),
        .fill_len  (fill_len),
        .fill_color(fill_color),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .vm_wr     (vm_wr),
        .vm_addr   (vm_addr),
        .vm_data   (vm_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Reference model: a pending fill job described by pointer/bytes-left,
    // plus a flag for the one completion cycle.
    bit          m_job;
    bit          m_finish;
    logic [31:0] m_ptr;
    int          m_left;
    logic [7:0]  m_color;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [7:0]  e_data;

    // Observation logs for the directed scenarios.
    logic [31:0] log_a[$];
    logic [7:0]  log_d[$];
    int          done_cnt;
    int          busy_cnt;
    int          done_at;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_job = 0; m_finish = 0; m_ptr = '0; m_left = 0; m_color = '0;
        e_wr = 1'b0; e_addr = '0; e_data = '0;
    endtask

    // One clock edge worth of behaviour, derived from the write-priority rules.
    task automatic model_update();
        if (reset) begin
            model_reset();
            return;
        end
        e_wr = 1'b0;
        if (cpu_wr && cpu_addr < PC) begin
            e_wr = 1'b1; e_addr = cpu_addr; e_data = cpu_data;
        end
        if (m_finish) begin
            m_finish = 0;
        end else if (m_job) begin
            if (fill_abort) begin
                m_job = 0;
            end else if (m_ptr >= PC) begin
                m_job = 0; m_finish = 1;
            end else if (!cpu_wr) begin
                e_wr = 1'b1; e_addr = m_ptr; e_data = m_color;
                m_ptr  = m_ptr + 32'd1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_job = 0; m_finish = 1;
                end
            end
        end else if (fill_start) begin
            m_ptr = fill_base; m_left = int'(fill_len); m_color = fill_color;
            if (fill_len == 0) m_finish = 1;
            else               m_job    = 1;
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        model_update();
        @(negedge cpu_clk);
        chk("vm_wr",     32'(vm_wr),     32'(e_wr));
        chk("vm_addr",   vm_addr,        e_addr);
        chk("vm_data",   32'(vm_data),   32'(e_data));
        chk("fill_busy", 32'(fill_busy), 32'(m_job | m_finish));
        chk("fill_done", 32'(fill_done), 32'(m_finish));
        cyc++;
        if (vm_wr) begin
            log_a.push_back(vm_addr);
            log_d.push_back(vm_data);
        end
        if (fill_done) begin
            done_cnt++;
            done_at = cyc;
        end
        if (fill_busy) busy_cnt++;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete();
        done_cnt = 0; busy_cnt = 0; done_at = -1; cyc = 0;
    endtask

    task automatic quiet();
        cpu_wr = 1'b0; fill_start = 1'b0; fill_abort = 1'b0;
    endtask

    task automatic start_fill(input logic [31:0] base, input logic [17:0] len, input logic [7:0] col);
        fill_start = 1'b1; fill_base = base; fill_len = len; fill_color = col;
    endtask

    // Compare the write log against an expected address/data list of length n.
    task automatic chk_log(input string tag, input logic [31:0] ea[8], input logic [7:0] ed[8], input int n);
        chk({tag, "_count"}, 32'(log_a.size()), 32'(n));
        for (int i = 0; i < n && i < log_a.size(); i++) begin
            chk({tag, "_addr"}, log_a[i], ea[i]);
            chk({tag, "_data"}, 32'(log_d[i]), 32'(ed[i]));
        end
    endtask

    logic [31:0] xa[8];
    logic [7:0]  xd[8];

    initial begin
        reset = 1'b1;
        cpu_addr = '0; cpu_data = '0; fill_base = '0; fill_len = '0; fill_color = '0;
        quiet();
        model_reset();
        clear_logs();

        // Reset state.
        step(); step();
        reset = 1'b0;
        step();

        // Plain fill of 4 bytes.
        clear_logs();
        start_fill(32'd100, 18'd4, 8'hE0);
        step();
        quiet();
        repeat (7) step();
        for (int i = 0; i < 4; i++) begin xa[i] = 32'(100 + i); xd[i] = 8'hE0; end
        chk_log("plain", xa, xd, 4);
        chk("plain_done_cnt", 32'(done_cnt), 32'd1);
        chk("plain_busy_cycles", 32'(busy_cnt), 32'd5);
        chk("plain_done_at", 32'(done_at), 32'd5);

        // Same fill with a CPU write on the second fill cycle.
        clear_logs();
        start_fill(32'd100, 18'd4, 8'hE0);
        step();
        quiet();
        step();
        cpu_wr = 1'b1; cpu_addr = 32'd5; cpu_data = 8'h1C;
        step();
        quiet();
        repeat (6) step();
        xa[0] = 32'd100; xd[0] = 8'hE0;
        xa[1] = 32'd5;   xd[1] = 8'h1C;
        for (int i = 2; i < 5; i++) begin xa[i] = 32'(99 + i); xd[i] = 8'hE0; end
        chk_log("cpu_prio", xa, xd, 5);
        chk("cpu_prio_done_at", 32'(done_at), 32'd6);
        chk("cpu_prio_done_cnt", 32'(done_cnt), 32'd1);

        // Fill clipped at the end of the framebuffer.
        clear_logs();
        start_fill(32'd255998, 18'd10, 8'h4A);
        step();
        quiet();
        repeat (7) step();
        xa[0] = 32'd255998; xd[0] = 8'h4A;
        xa[1] = 32'd255999; xd[1] = 8'h4A;
        chk_log("clip", xa, xd, 2);
        chk("clip_done_cnt", 32'(done_cnt), 32'd1);

        // Zero-length fill: straight to completion, no writes.
        clear_logs();
        start_fill(32'd300, 18'd0, 8'h11);
        step();
        quiet();
        repeat (3) step();
        chk("len0_writes", 32'(log_a.size()), 32'd0);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);
        chk("len0_done_at", 32'(done_at), 32'd1);

        // Abort after 3 fill writes; a CPU write in the abort cycle still lands.
        clear_logs();
        start_fill(32'd1000, 18'd100, 8'h03);
        step();
        quiet();
        repeat (3) step();
        fill_abort = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'd7; cpu_data = 8'h55;
        step();
        quiet();
        step();
        chk("abort_busy", 32'(fill_busy), 32'd0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin xa[i] = 32'(1000 + i); xd[i] = 8'h03; end
        xa[3] = 32'd7; xd[3] = 8'h55;
        chk_log("abort", xa, xd, 4);
        clear_logs();
        start_fill(32'd50, 18'd2, 8'hAA);
        step();
        quiet();
        repeat (4) step();
        xa[0] = 32'd50; xd[0] = 8'hAA;
        xa[1] = 32'd51; xd[1] = 8'hAA;
        chk_log("refill", xa, xd, 2);
        chk("refill_done_cnt", 32'(done_cnt), 32'd1);

        // Asynchronous reset mid-fill: outputs clear before the next edge.
        start_fill(32'd2000, 18'd50, 8'h77);
        step();
        quiet();
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_vm_wr",   32'(vm_wr),     32'd0);
        chk("rst_async_vm_addr", vm_addr,        32'd0);
        chk("rst_async_vm_data", 32'(vm_data),   32'd0);
        chk("rst_async_busy",    32'(fill_busy), 32'd0);
        chk("rst_async_done",    32'(fill_done), 32'd0);
        model_reset();
        step(); step();
        reset = 1'b0;
        step();
        chk("post_rst_no_write", 32'(vm_wr), 32'd0);
        cpu_wr = 1'b1; cpu_addr = 32'd256000; cpu_data = 8'hFF;
        step();
        chk("oob_cpu_dropped", 32'(vm_wr), 32'd0);
        cpu_addr = 32'd255999; cpu_data = 8'h5A;
        step();
        chk("last_cpu_addr", 32'(vm_wr), 32'd1);
        quiet();
        step();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            cpu_wr     = ($urandom_range(0, 9) < 3);
            cpu_addr   = ($urandom_range(0, 9) == 0) ? 32'(PC + $urandom_range(0, 3))
                                                     : 32'($urandom_range(0, PC - 1));
            cpu_data   = 8'($urandom);
            fill_start = ($urandom_range(0, 9) == 0);
            fill_abort = ($urandom_range(0, 29) == 0);
            fill_base  = ($urandom_range(0, 3) == 0) ? 32'(PC - $urandom_range(0, 6))
                                                     : 32'($urandom_range(0, 1000));
            fill_len   = 18'($urandom_range(0, 12));
            fill_color = 8'($urandom);
            step();
        end
        quiet();
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
